// File: rtl/icache_victim_buffer.sv
// -----------------------------------------------------------------------------
// icache_victim_buffer
//
// Small fully-associative victim cache that sits beside the direct-mapped
// instruction cache. Lines the icache evicts on a refill are captured here;
// a fetch whose block address matches a resident entry is answered in the
// same cycle, so the icache can skip its memory request and the fetch stage
// can take the instruction word from vcache_data instead.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high reset
//   victimen         icache is overwriting a line this cycle
//   victimidx        index of the evicted line
//   victim_tag       tag of the evicted line
//   victim_data      64-bit data of the evicted line
//   victim_valid     valid bit of the evicted line (invalid evictions ignored)
//   proc2Icache_addr fetch address; block address is bits [BLK_BITS+2:3]
//   vcachehit        a valid entry matches the fetch block address
//   vcache_data      data of the matching entry, 0 when there is no hit
//   vc_occupancy     number of valid entries
// -----------------------------------------------------------------------------
module icache_victim_buffer #(
    parameter int VC_LINES        = 4,
    parameter int CACHE_LINE_BITS = 5,
    parameter int BLK_BITS        = 13,
    parameter int XLEN            = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  victimen,
    input  logic [CACHE_LINE_BITS-1:0]            victimidx,
    input  logic [BLK_BITS-CACHE_LINE_BITS-1:0]   victim_tag,
    input  logic [63:0]                           victim_data,
    input  logic                                  victim_valid,
    input  logic [XLEN-1:0]                       proc2Icache_addr,
    output logic                                  vcachehit,
    output logic [63:0]                           vcache_data,
    output logic [$clog2(VC_LINES):0]             vc_occupancy
);

    localparam int AW = $clog2(VC_LINES);

    // Entry storage. Ages form a permutation of 0..VC_LINES-1 at all times;
    // age 0 is most recently used, age VC_LINES-1 is the replacement victim.
    logic                valid_reg [VC_LINES];
    logic [BLK_BITS-1:0] blk_reg   [VC_LINES];
    logic [63:0]         data_reg  [VC_LINES];
    logic [AW-1:0]       age_reg   [VC_LINES];
    logic [AW:0]         occupancy_reg;

    logic [BLK_BITS-1:0] lookup_key;
    logic [BLK_BITS-1:0] new_blk;
    logic                ins_en;

    logic [VC_LINES-1:0] hit_vec;
    logic [VC_LINES-1:0] match_vec;
    logic [VC_LINES-1:0] lru_vec;

    logic                hit_any;
    logic [AW-1:0]       hit_idx;
    logic [63:0]         data_mux;
    logic                match_any;
    logic [AW-1:0]       match_idx;
    logic                inval_any;
    logic [AW-1:0]       inval_idx;
    logic [AW-1:0]       lru_idx;
    logic [AW-1:0]       target_idx;
    logic                touch_en;
    logic [AW-1:0]       touch_idx;
    logic [AW-1:0]       touch_age;

    // Address bits outside the block-address field play no part here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc2Icache_addr[XLEN-1:BLK_BITS+3], proc2Icache_addr[2:0]};

    assign lookup_key = proc2Icache_addr[BLK_BITS+2:3];
    assign new_blk    = {victim_tag, victimidx};
    assign ins_en     = victimen && victim_valid;

    // Per-entry comparators.
    generate
        for (genvar gi = 0; gi < VC_LINES; gi++) begin : g_cmp
            assign hit_vec[gi]   = valid_reg[gi] && (blk_reg[gi] == lookup_key);
            assign match_vec[gi] = valid_reg[gi] && (blk_reg[gi] == new_blk);
            assign lru_vec[gi]   = (age_reg[gi] == AW'(VC_LINES - 1));
        end
    endgenerate

    assign hit_any = |hit_vec;

    // Encoders and the one-hot data mux. Inserts never create duplicate
    // blocks, so hit_vec and match_vec each have at most one bit set.
    always_comb begin
        hit_idx   = '0;
        data_mux  = '0;
        match_any = 1'b0;
        match_idx = '0;
        inval_any = 1'b0;
        inval_idx = '0;
        lru_idx   = '0;
        for (int i = 0; i < VC_LINES; i++) begin
            data_mux = data_mux | (data_reg[i] & {64{hit_vec[i]}});
            if (hit_vec[i]) begin
                hit_idx = AW'(i);
            end
            if (match_vec[i]) begin
                match_any = 1'b1;
                match_idx = AW'(i);
            end
            if (lru_vec[i]) begin
                lru_idx = AW'(i);
            end
        end
        // Scan downwards so the lowest-numbered invalid entry wins.
        for (int i = VC_LINES - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                inval_any = 1'b1;
                inval_idx = AW'(i);
            end
        end
    end

    // Insert target: existing copy first, then a free slot, then the LRU entry.
    always_comb begin
        if (match_any) begin
            target_idx = match_idx;
        end else if (inval_any) begin
            target_idx = inval_idx;
        end else begin
            target_idx = lru_idx;
        end
    end

    // An insert owns the recency update; a lookup hit only touches its entry
    // when no insert happens in the same cycle.
    assign touch_en  = ins_en || hit_any;
    assign touch_idx = ins_en ? target_idx : hit_idx;
    assign touch_age = age_reg[touch_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < VC_LINES; i++) begin
                valid_reg[i] <= 1'b0;
                blk_reg[i]   <= '0;
                data_reg[i]  <= '0;
                age_reg[i]   <= AW'(i);
            end
            occupancy_reg <= '0;
        end else begin
            if (ins_en) begin
                valid_reg[target_idx] <= 1'b1;
                blk_reg[target_idx]   <= new_blk;
                data_reg[target_idx]  <= victim_data;
                if (!match_any && inval_any) begin
                    occupancy_reg <= occupancy_reg + {{AW{1'b0}}, 1'b1};
                end
            end
            if (touch_en) begin
                for (int i = 0; i < VC_LINES; i++) begin
                    if (AW'(i) == touch_idx) begin
                        age_reg[i] <= '0;
                    end else if (age_reg[i] < touch_age) begin
                        age_reg[i] <= age_reg[i] + AW'(1);
                    end
                end
            end
        end
    end

    assign vcachehit    = hit_any;
    assign vcache_data  = data_mux;
    assign vc_occupancy = occupancy_reg;

endmodule
